fir_output_range_monitor: RTL and testbench

FIR_OUTPUT_RANGE_MONITOR -- requirements
Module: fir_output_range_monitor

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_out_saturate.sv | 83 ++++++++
 rtl/fir_output_range_monitor.sv | 166 ++++++++++++++++
 tb/tb_fir_output_range_monitor.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared defaults, saturation limits and FSM encoding for the
//                FIR output range monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int IN_WIDTH_DEF   = 32;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_SHIFT_DEF = 15;
    localparam int WINDOW_LEN_DEF = 256;
    localparam int SUM_WIDTH      = 40;

    // Two's-complement limits of a signed sample of the given width.
    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCUM  = 2'd1;
    localparam state_t ST_REPORT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fir_out_saturate.sv
`default_nettype none
// ============================================================================
//  Module      : fir_out_saturate
//  Description : Round-half-up, shift and saturate a FIR accumulator word to
//                a DATA_WIDTH sample; one registered stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_out_saturate
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [IN_WIDTH-1:0]   data_in,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         clip
);

    localparam int YW = IN_WIDTH + 1;

    localparam logic signed [YW-1:0]         RND      = YW'(64'sd1 <<< (FRAC_SHIFT - 1));
    localparam logic signed [YW-1:0]         Y_MAX    = YW'(sat_max(DATA_WIDTH));
    localparam logic signed [YW-1:0]         Y_MIN    = YW'(sat_min(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [YW-1:0]         ext_w;
    logic signed [YW-1:0]         y_w;
    logic signed [DATA_WIDTH-1:0] sat_w;
    logic                         sat_clip_w;

    logic signed [DATA_WIDTH-1:0] data_d, data_q;
    logic                         clip_d, clip_q;
    logic                         valid_q;

    // One guard bit keeps the rounding add from wrapping at full-scale input.
    always_comb begin
        ext_w = YW'(data_in) + RND;
        y_w   = ext_w >>> FRAC_SHIFT;
        if (y_w > Y_MAX) begin
            sat_w      = DATA_MAX;
            sat_clip_w = 1'b1;
        end else if (y_w < Y_MIN) begin
            sat_w      = DATA_MIN;
            sat_clip_w = 1'b1;
        end else begin
            sat_w      = y_w[DATA_WIDTH-1:0];
            sat_clip_w = 1'b0;
        end
    end

    always_comb begin
        data_d = data_q;
        clip_d = clip_q;
        if (in_valid) begin
            data_d = sat_w;
            clip_d = sat_clip_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            clip_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            data_q  <= data_d;
            clip_q  <= clip_d;
        end
    end

    assign out_valid = valid_q;
    assign data_out  = data_q;
    assign clip      = clip_q;

endmodule
`default_nettype wire

// File: rtl/fir_output_range_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fir_output_range_monitor
//  Description : Rounds/saturates FIR output and gathers per-window peak,
//                mean-square and clip statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_output_range_monitor
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int WINDOW_LEN = WINDOW_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         continuous,
    input  logic                         in_valid,
    input  logic signed [IN_WIDTH-1:0]   data_in,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         clip,
    output logic                         busy,
    output logic                         win_done,
    output logic [15:0]                  peak_abs,
    output logic [31:0]                  mean_sq,
    output logic [15:0]                  clip_count
);

    localparam int               CNT_W    = $clog2(WINDOW_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_LEN - 1);

    logic                         out_valid_w;
    logic signed [DATA_WIDTH-1:0] data_out_w;
    logic                         clip_w;

    fir_out_saturate #(
        .IN_WIDTH   (IN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid_w),
        .data_out  (data_out_w),
        .clip      (clip_w)
    );

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]   peak_q, peak_d;
    logic [SUM_WIDTH-1:0]    sum_q, sum_d;
    logic [15:0]             clipc_q, clipc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [15:0]             peak_res_q, peak_res_d;
    logic [31:0]             mean_res_q, mean_res_d;
    logic [15:0]             clipc_res_q, clipc_res_d;

    logic [DATA_WIDTH-1:0]       mag_w;
    logic signed [2*DATA_WIDTH-1:0] sq_w;
    logic [DATA_WIDTH-1:0]       peak_upd_w;
    logic [SUM_WIDTH-1:0]        sum_upd_w;
    logic [15:0]                 clipc_upd_w;
    logic                        acc_en_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCUM;
            ST_ACCUM:  if (out_valid_w && (count_q == CNT_LAST)) state_d = ST_REPORT;
            ST_REPORT: state_d = continuous ? ST_ACCUM : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        win_done = (state_q == ST_REPORT);
    end

    // The unsigned magnitude of the most negative sample still fits DATA_WIDTH bits.
    always_comb begin
        mag_w       = data_out_w[DATA_WIDTH-1] ? -data_out_w : data_out_w;
        sq_w        = (2*DATA_WIDTH)'(data_out_w) * (2*DATA_WIDTH)'(data_out_w);
        peak_upd_w  = (mag_w > peak_q) ? mag_w : peak_q;
        sum_upd_w   = sum_q + SUM_WIDTH'($unsigned(sq_w));
        clipc_upd_w = (clip_w && (clipc_q != 16'hFFFF)) ? clipc_q + 16'd1 : clipc_q;
        acc_en_w    = out_valid_w &&
                      ((state_q == ST_ACCUM) || ((state_q == ST_REPORT) && continuous));
    end

    // Accumulators idle at zero, so a REPORT-cycle sample starts the next window cleanly.
    always_comb begin
        peak_d      = peak_q;
        sum_d       = sum_q;
        clipc_d     = clipc_q;
        count_d     = count_q;
        peak_res_d  = peak_res_q;
        mean_res_d  = mean_res_q;
        clipc_res_d = clipc_res_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                peak_d  = '0;
                sum_d   = '0;
                clipc_d = '0;
                count_d = '0;
            end
        end else if (acc_en_w) begin
            if ((state_q == ST_ACCUM) && (count_q == CNT_LAST)) begin
                peak_res_d  = 16'(peak_upd_w);
                mean_res_d  = 32'(sum_upd_w >> CNT_W);
                clipc_res_d = clipc_upd_w;
                peak_d      = '0;
                sum_d       = '0;
                clipc_d     = '0;
                count_d     = '0;
            end else begin
                peak_d  = peak_upd_w;
                sum_d   = sum_upd_w;
                clipc_d = clipc_upd_w;
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q      <= '0;
            sum_q       <= '0;
            clipc_q     <= '0;
            count_q     <= '0;
            peak_res_q  <= '0;
            mean_res_q  <= '0;
            clipc_res_q <= '0;
        end else begin
            peak_q      <= peak_d;
            sum_q       <= sum_d;
            clipc_q     <= clipc_d;
            count_q     <= count_d;
            peak_res_q  <= peak_res_d;
            mean_res_q  <= mean_res_d;
            clipc_res_q <= clipc_res_d;
        end
    end

    assign out_valid  = out_valid_w;
    assign data_out   = data_out_w;
    assign clip       = clip_w;
    assign peak_abs   = peak_res_q;
    assign mean_sq    = mean_res_q;
    assign clip_count = clipc_res_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_output_range_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_output_range_monitor
//  Description : Scoreboard bench for the FIR output range monitor
//                (WINDOW_LEN = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_output_range_monitor;

    localparam int WL = 4;
    localparam int FS = 15;

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b0;
    logic               start      = 1'b0;
    logic               continuous = 1'b0;
    logic               in_valid   = 1'b0;
    logic signed [31:0] data_in    = '0;
    logic               out_valid;
    logic signed [15:0] data_out;
    logic               clip;
    logic               busy;
    logic               win_done;
    logic [15:0]        peak_abs;
    logic [31:0]        mean_sq;
    logic [15:0]        clip_count;

    typedef struct packed { logic signed [15:0] d; logic c; } samp_t;
    typedef struct packed { logic [15:0] peak; logic [31:0] msq; logic [15:0] cc; } win_t;

    samp_t  exp_q[$];
    win_t   win_q[$];
    int     checks    = 0;
    int     errors    = 0;
    int     win_count = 0;
    longint m_peak = 0, m_sum = 0, m_cc = 0;
    int     m_cnt  = 0;

    fir_output_range_monitor #(.WINDOW_LEN(WL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .clip       (clip),
        .busy       (busy),
        .win_done   (win_done),
        .peak_abs   (peak_abs),
        .mean_sq    (mean_sq),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;

    function automatic samp_t model(input logic signed [31:0] d);
        longint y;
        samp_t  s;
        y = (longint'(d) + (64'sd1 <<< (FS - 1))) >>> FS;
        if (y > 32767) begin
            s.d = 16'sh7FFF; s.c = 1'b1;
        end else if (y < -32768) begin
            s.d = 16'sh8000; s.c = 1'b1;
        end else begin
            s.d = 16'(y);    s.c = 1'b0;
        end
        return s;
    endfunction

    function automatic logic signed [31:0] q15(input longint y);
        return 32'(y * 32768);
    endfunction

    task automatic model_count(input samp_t s);
        longint v;
        longint a;
        win_t   w;
        v = longint'(s.d);
        a = (v < 0) ? -v : v;
        if (a > m_peak) m_peak = a;
        m_sum = m_sum + v * v;
        if (s.c && m_cc < 65535) m_cc = m_cc + 1;
        m_cnt = m_cnt + 1;
        if (m_cnt == WL) begin
            w.peak = 16'(m_peak);
            w.msq  = 32'(m_sum >>> $clog2(WL));
            w.cc   = 16'(m_cc);
            win_q.push_back(w);
            m_peak = 0; m_sum = 0; m_cc = 0; m_cnt = 0;
        end
    endtask

    task automatic send(input logic signed [31:0] d, input bit counted);
        samp_t s;
        @(posedge clk); #1;
        in_valid = 1'b1;
        data_in  = d;
        s = model(d);
        exp_q.push_back(s);
        if (counted) model_count(s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            data_in  = '0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || win_q.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || win_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending samples=%0d windows=%0d, expected 0/0",
                     exp_q.size(), win_q.size());
        end
    endtask

    // Scoreboard: pop one expectation per out_valid and per win_done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sample: unexpected out_valid data_out=%0d", data_out);
                end else begin
                    samp_t e;
                    e = exp_q.pop_front();
                    if (data_out !== e.d || clip !== e.c) begin
                        errors++;
                        $display("FAIL sample: got data_out=%0d clip=%0b, expected %0d/%0b",
                                 data_out, clip, e.d, e.c);
                    end
                end
            end
            if (win_done) begin
                win_count++;
                checks++;
                if (win_q.size() == 0) begin
                    errors++;
                    $display("FAIL window: unexpected win_done peak=%0d msq=%0d cc=%0d",
                             peak_abs, mean_sq, clip_count);
                end else begin
                    win_t w;
                    w = win_q.pop_front();
                    if (peak_abs !== w.peak || mean_sq !== w.msq || clip_count !== w.cc) begin
                        errors++;
                        $display("FAIL window: got peak=%0d msq=%0d cc=%0d, expected %0d/%0d/%0d",
                                 peak_abs, mean_sq, clip_count, w.peak, w.msq, w.cc);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({out_valid, clip, busy, win_done} !== 4'b0 || data_out !== 16'sd0 ||
            peak_abs !== 16'd0 || mean_sq !== 32'd0 || clip_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: ov=%0b clip=%0b busy=%0b wd=%0b d=%0d pk=%0d msq=%0d cc=%0d, expected all 0",
                     out_valid, clip, busy, win_done, data_out, peak_abs, mean_sq, clip_count);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_round();
        int w0;
        w0 = win_count;
        send(32'sd16384, 1'b0);
        send(32'sd16383, 1'b0);
        send(-32'sd16385, 1'b0);
        send(32'sd49152, 1'b0);
        send(-32'sd49152, 1'b0);
        idle(2);
        drain();
        checks++;
        if (busy !== 1'b0 || win_count !== w0) begin
            errors++;
            $display("FAIL round_idle: busy=%0b windows=%0d, expected 0/%0d", busy, win_count, w0);
        end
    endtask

    task automatic test_saturate();
        send(32'sh4000_0000, 1'b0);
        send(-32'sd1073741824, 1'b0);
        send(-32'sd1073774592, 1'b0);
        send(32'sh7FFF_FFFF, 1'b0);
        send(32'sh8000_0000, 1'b0);
        send(q15(32767) + 32'sd16383, 1'b0);
        send(q15(32767) + 32'sd16384, 1'b0);
        idle(2);
        drain();
    endtask

    task automatic test_single_window();
        longint vals[4] = '{100, -300, 200, -50};
        int w0;
        w0 = win_count;
        continuous = 1'b0;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: busy=%0b, expected 1", busy);
        end
        foreach (vals[i]) send(q15(vals[i]), 1'b1);
        idle(5);
        drain();
        checks++;
        if (win_count !== w0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: windows=%0d busy=%0b, expected %0d/0", win_count, busy, w0 + 1);
        end
        checks++;
        if (peak_abs !== 16'd300 || mean_sq !== 32'd35625 || clip_count !== 16'd0) begin
            errors++;
            $display("FAIL single_result: peak=%0d msq=%0d cc=%0d, expected 300/35625/0",
                     peak_abs, mean_sq, clip_count);
        end
    endtask

    task automatic test_spaced();
        longint vals[4] = '{100, -300, 200, -50};
        int w0;
        w0 = win_count;
        continuous = 1'b0;
        // A sample whose out_valid coincides with the start cycle must not count.
        send(q15(1000), 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(q15(vals[i]), 1'b1);
            idle(3);
            if (i == 2) begin
                checks++;
                if (win_count !== w0) begin
                    errors++;
                    $display("FAIL spaced_early: windows=%0d, expected %0d", win_count, w0);
                end
            end
        end
        idle(2);
        drain();
        checks++;
        if (win_count !== w0 + 1 || peak_abs !== 16'd300 || mean_sq !== 32'd35625 ||
            clip_count !== 16'd0) begin
            errors++;
            $display("FAIL spaced_result: windows=%0d peak=%0d msq=%0d cc=%0d, expected %0d/300/35625/0",
                     win_count, peak_abs, mean_sq, clip_count, w0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        longint vals[12] = '{100, -200, 40000, -5, 7, -40000, 300, 1, -32768, 32767, 0, 12};
        int w0;
        w0 = win_count;
        continuous = 1'b1;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            send(q15(vals[i]), 1'b1);
            start = (i == 5);
        end
        start      = 1'b0;
        continuous = 1'b0;
        idle(5);
        drain();
        checks++;
        if (win_count !== w0 + 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_windows: windows=%0d busy=%0b, expected %0d/0", win_count, busy, w0 + 3);
        end
    endtask

    task automatic test_reset_midwindow();
        int w0;
        w0 = win_count;
        continuous = 1'b0;
        pulse_start();
        send(q15(1234), 1'b1);
        send(q15(-2345), 1'b1);
        send(q15(777), 1'b1);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        #1;
        exp_q.delete();
        win_q.delete();
        m_peak = 0; m_sum = 0; m_cc = 0; m_cnt = 0;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 16'sd0 || clip !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stage: ov=%0b d=%0d clip=%0b, expected 0/0/0", out_valid, data_out, clip);
        end
        checks++;
        if (busy !== 1'b0 || win_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_fsm: busy=%0b wd=%0b, expected 0/0", busy, win_done);
        end
        checks++;
        if (peak_abs !== 16'd0 || mean_sq !== 32'd0 || clip_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_results: peak=%0d msq=%0d cc=%0d, expected 0/0/0",
                     peak_abs, mean_sq, clip_count);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);
        checks++;
        if (win_count !== w0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: windows=%0d busy=%0b, expected %0d/0", win_count, busy, w0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round();
        test_saturate();
        test_single_window();
        test_spaced();
        test_back_to_back();
        test_reset_midwindow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
